// File: rtl/hit_judge_multi.sv
// hit_judge_multi: latches a target on start, times the response window and judges the first switch toggle
module hit_judge_multi #(
  parameter int N = 8,
  parameter int WINDOW = 100000000,
  parameter int MIN_REACT = 10,
  parameter int SCORE_W = 16,
  parameter int CW = $clog2(WINDOW + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N-1:0]       target,
  input  logic [N-1:0]       switch,
  output logic [N-1:0]       led_out,
  output logic               busy,
  output logic               hit,
  output logic               miss,
  output logic               timeout,
  output logic               false_start,
  output logic [CW-1:0]      reaction,
  output logic [SCORE_W-1:0] hit_count,
  output logic [SCORE_W-1:0] miss_count
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [CW-1:0] WIN = CW'(WINDOW);
  state_t state;
  logic [CW-1:0] cnt;
  logic [N-1:0] tgt, sw_prev, chg;
  logic primed, toggled, good;
  assign chg = switch ^ sw_prev;
  assign toggled = primed && (chg != '0);
  assign good = (chg == tgt) && (32'(cnt) >= MIN_REACT);
  // sw_prev is meaningless until the first post-reset edge, so primed blocks any verdict there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      tgt <= '0;
      sw_prev <= '0;
      primed <= 1'b0;
      led_out <= '0;
      busy <= 1'b0;
      hit <= 1'b0;
      miss <= 1'b0;
      timeout <= 1'b0;
      false_start <= 1'b0;
      reaction <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      sw_prev <= switch;
      primed <= 1'b1;
      hit <= 1'b0;
      miss <= 1'b0;
      timeout <= 1'b0;
      false_start <= 1'b0;
      if (state == IDLE) begin
        if (toggled) begin
          miss <= 1'b1;
          false_start <= 1'b1;
          if (~&miss_count) miss_count <= miss_count + SCORE_W'(1);
        end else if (primed && start) begin
          state <= ACTIVE;
          tgt <= target;
          cnt <= CW'(1);
          led_out <= target;
          busy <= 1'b1;
        end
      end else if (toggled || cnt == WIN) begin
        state <= IDLE;
        cnt <= '0;
        led_out <= '0;
        busy <= 1'b0;
        reaction <= cnt;
        hit <= toggled && good;
        miss <= !(toggled && good);
        timeout <= !toggled;
        if (toggled && good) begin
          if (~&hit_count) hit_count <= hit_count + SCORE_W'(1);
        end else if (~&miss_count) miss_count <= miss_count + SCORE_W'(1);
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule
